// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory stage.
package mem_stage_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int DATA_WORDS_DEF  = 256;
  localparam int MEM_LATENCY_DEF = 2;

  // Counter must hold 0..latency-1 and is never narrower than 2 bits.
  function automatic int cnt_width(input int latency);
    return (latency <= 4) ? 2 : $clog2(latency);
  endfunction

endpackage

// File: rtl/defines.sv
// Global datapath widths shared by every pipeline stage.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef INSTRUCTION_LEN
`define INSTRUCTION_LEN 32
`endif

// File: rtl/mem_stage_data_memory.sv
// Word-addressed data memory: synchronous write, asynchronous read, no reset.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module data_memory #(
  parameter int DATA_WORDS = 256,
  parameter int ADDR_W     = $clog2(DATA_WORDS)
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [`WORD_LEN-1:0] wdata_i,
  output logic [`WORD_LEN-1:0] rdata_o
);

  logic [`WORD_LEN-1:0] mem_q [DATA_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // Read sees the pre-write contents in the same cycle as a write.
  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// Memory stage with multi-cycle data-memory access, front-end stall and the
// MEM/WB pipeline register.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef INSTRUCTION_LEN
`define INSTRUCTION_LEN 32
`endif

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WORDS  = DATA_WORDS_DEF,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [`WORD_LEN-1:0]        PR3_alu_out,
  input  logic [`WORD_LEN-1:0]        PR3_RF_out2,
  input  logic [`INSTRUCTION_LEN-1:0] PR3_instruction,
  input  logic                        PR3_MEM_read,
  input  logic                        PR3_MEM_write,
  input  logic                        PR3_sel_RF_write_src_ALU,
  input  logic                        PR3_sel_RF_write_src_MEM,
  input  logic                        PR3_RF_write_en,
  output logic                        mem_stall,
  output logic [`WORD_LEN-1:0]        PR4_alu_out,
  output logic [`WORD_LEN-1:0]        PR4_mem_data,
  output logic [`WORD_LEN-1:0]        PR4_write_data,
  output logic [`INSTRUCTION_LEN-1:0] PR4_instruction,
  output logic                        PR4_RF_write_en
);

  localparam int ADDR_W = $clog2(DATA_WORDS);
  localparam int CNT_W  = cnt_width(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        mem_op;
  logic                        stall_raw;
  logic                        complete;
  logic                        mem_we;
  logic [ADDR_W-1:0]           addr;
  logic [`WORD_LEN-1:0]        rdata;
  logic [`WORD_LEN-1:0]        wb_data;

  logic [`WORD_LEN-1:0]        alu_q, alu_d;
  logic [`WORD_LEN-1:0]        mdata_q, mdata_d;
  logic [`WORD_LEN-1:0]        wdata_q, wdata_d;
  logic [`INSTRUCTION_LEN-1:0] instr_q, instr_d;
  logic                        rfwe_q, rfwe_d;

  // ALU select is implied when MEM is not selected; upper address bits wrap.
  logic unused_ok;
  assign unused_ok = ^{PR3_sel_RF_write_src_ALU, PR3_alu_out[`WORD_LEN-1:ADDR_W]};

  assign mem_op = PR3_MEM_read | PR3_MEM_write;
  assign addr   = PR3_alu_out[ADDR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    complete  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (MEM_LATENCY == 1) begin
            complete = 1'b1;
          end else begin
            stall_raw = 1'b1;
            state_d   = ACCESS;
            cnt_d     = CNT_W'(1);
          end
        end
      end
      ACCESS: begin
        if (!mem_op) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          complete = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          stall_raw = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Gating with rst keeps the write from landing on an aborted access.
  assign mem_stall = stall_raw & mem_op & ~rst;
  assign mem_we    = complete & PR3_MEM_write & ~rst;

  data_memory #(
    .DATA_WORDS (DATA_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_dmem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (addr),
    .wdata_i (PR3_RF_out2),
    .rdata_o (rdata)
  );

  assign wb_data = PR3_sel_RF_write_src_MEM ? rdata : PR3_alu_out;

  always_comb begin
    alu_d   = alu_q;
    mdata_d = mdata_q;
    wdata_d = wdata_q;
    instr_d = instr_q;
    rfwe_d  = rfwe_q;
    if (mem_stall) begin
      instr_d = '0;
      rfwe_d  = 1'b0;
    end else begin
      alu_d   = PR3_alu_out;
      mdata_d = rdata;
      wdata_d = wb_data;
      instr_d = PR3_instruction;
      rfwe_d  = PR3_RF_write_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_q   <= '0;
      mdata_q <= '0;
      wdata_q <= '0;
      instr_q <= '0;
      rfwe_q  <= 1'b0;
    end else begin
      alu_q   <= alu_d;
      mdata_q <= mdata_d;
      wdata_q <= wdata_d;
      instr_q <= instr_d;
      rfwe_q  <= rfwe_d;
    end
  end

  assign PR4_alu_out     = alu_q;
  assign PR4_mem_data    = mdata_q;
  assign PR4_write_data  = wdata_q;
  assign PR4_instruction = instr_q;
  assign PR4_RF_write_en = rfwe_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: instance 0 uses MEM_LATENCY=2, instance 1 MEM_LATENCY=1.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef INSTRUCTION_LEN
`define INSTRUCTION_LEN 32
`endif

module tb_mem_stage;

  typedef struct {
    logic [`WORD_LEN-1:0]        alu;
    logic [`WORD_LEN-1:0]        mdata;
    logic [`WORD_LEN-1:0]        wdata;
    logic [`INSTRUCTION_LEN-1:0] ins;
    logic                        we;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [`WORD_LEN-1:0]        alu_i [2];
  logic [`WORD_LEN-1:0]        rf2_i [2];
  logic [`INSTRUCTION_LEN-1:0] ins_i [2];
  logic rd_i [2], wr_i [2], salu_i [2], smem_i [2], rfwe_i [2];
  logic stall_o [2];
  logic [`WORD_LEN-1:0]        p4alu [2], p4md [2], p4wd [2];
  logic [`INSTRUCTION_LEN-1:0] p4ins [2];
  logic                        p4we [2];

  logic [`WORD_LEN-1:0] mdl [2][256];
  exp_t sbq0 [$];
  exp_t sbq1 [$];
  int tests = 0;
  int fails = 0;

  mem_stage #(.DATA_WORDS(256), .MEM_LATENCY(2)) dut_lat2 (
    .clk(clk), .rst(rst),
    .PR3_alu_out(alu_i[0]), .PR3_RF_out2(rf2_i[0]), .PR3_instruction(ins_i[0]),
    .PR3_MEM_read(rd_i[0]), .PR3_MEM_write(wr_i[0]),
    .PR3_sel_RF_write_src_ALU(salu_i[0]), .PR3_sel_RF_write_src_MEM(smem_i[0]),
    .PR3_RF_write_en(rfwe_i[0]), .mem_stall(stall_o[0]),
    .PR4_alu_out(p4alu[0]), .PR4_mem_data(p4md[0]), .PR4_write_data(p4wd[0]),
    .PR4_instruction(p4ins[0]), .PR4_RF_write_en(p4we[0]));

  mem_stage #(.DATA_WORDS(256), .MEM_LATENCY(1)) dut_lat1 (
    .clk(clk), .rst(rst),
    .PR3_alu_out(alu_i[1]), .PR3_RF_out2(rf2_i[1]), .PR3_instruction(ins_i[1]),
    .PR3_MEM_read(rd_i[1]), .PR3_MEM_write(wr_i[1]),
    .PR3_sel_RF_write_src_ALU(salu_i[1]), .PR3_sel_RF_write_src_MEM(smem_i[1]),
    .PR3_RF_write_en(rfwe_i[1]), .mem_stall(stall_o[1]),
    .PR4_alu_out(p4alu[1]), .PR4_mem_data(p4md[1]), .PR4_write_data(p4wd[1]),
    .PR4_instruction(p4ins[1]), .PR4_RF_write_en(p4we[1]));

  task automatic drive(input int d, input logic [31:0] alu, input logic [31:0] rf2,
                       input logic [31:0] ins, input logic rd, input logic wr,
                       input logic smem, input logic we);
    alu_i[d]  = alu;
    rf2_i[d]  = rf2;
    ins_i[d]  = ins;
    rd_i[d]   = rd;
    wr_i[d]   = wr;
    smem_i[d] = smem;
    salu_i[d] = ~smem;
    rfwe_i[d] = we;
  endtask

  task automatic idle(input int d);
    drive(d, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the capture edge.
  // stalls = -1 when the access never completes.
  task automatic issue(input int d, input logic [31:0] alu, input logic [31:0] rf2,
                       input logic [31:0] ins, input logic rd, input logic wr,
                       input logic smem, input logic we,
                       output int stalls, output bit bub_bad);
    exp_t e;
    int a;
    bit s;
    a = int'(alu[7:0]);
    e.alu   = alu;
    e.mdata = mdl[d][a];
    e.wdata = smem ? mdl[d][a] : alu;
    e.ins   = ins;
    e.we    = we;
    if (d == 0) sbq0.push_back(e);
    else        sbq1.push_back(e);
    if (wr) mdl[d][a] = rf2;
    drive(d, alu, rf2, ins, rd, wr, smem, we);
    stalls  = 0;
    bub_bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      s = stall_o[d];
      @(posedge clk);
      #1;
      if (!s) return;
      stalls++;
      if (p4we[d] !== 1'b0 || p4ins[d] !== '0) bub_bad = 1'b1;
    end
    stalls = -1;
  endtask

  task automatic test_reset;
    exp_t e;
    int st;
    bit bb;
    drive(0, 32'h4, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    tests++;
    if ({p4alu[0], p4md[0], p4wd[0], p4ins[0], p4we[0]} !== '0) begin
      fails++; $display("FAIL reset_outputs: got nonzero PR4 bundle, want all 0");
    end
    tests++;
    if (stall_o[0] !== 1'b0) begin
      fails++; $display("FAIL reset_stall: got %b want 0", stall_o[0]);
    end
    idle(0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    issue(0, 32'h77, 32'h0, 32'h0A1, 1'b0, 1'b0, 1'b0, 1'b1, st, bb);
    e = sbq0.pop_front();
    tests++;
    if (p4wd[0] !== e.wdata || p4ins[0] !== e.ins) begin
      fails++; $display("FAIL pre_reset_alu: got wd=%h ins=%h want wd=%h ins=%h", p4wd[0], p4ins[0], e.wdata, e.ins);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({p4alu[0], p4md[0], p4wd[0], p4ins[0], p4we[0]} !== '0 || stall_o[0] !== 1'b0) begin
      fails++; $display("FAIL midrun_reset: got wd=%h we=%b stall=%b want 0", p4wd[0], p4we[0], stall_o[0]);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    issue(0, 32'h15, 32'h0, 32'h0A2, 1'b0, 1'b0, 1'b0, 1'b1, st, bb);
    e = sbq0.pop_front();
    tests++;
    if (st !== 0 || p4wd[0] !== 32'h15 || p4wd[0] !== e.wdata || p4we[0] !== 1'b1) begin
      fails++; $display("FAIL after_reset_alu: got stalls=%0d wd=%h we=%b want 0/15/1", st, p4wd[0], p4we[0]);
    end
  endtask

  task automatic test_passthrough;
    exp_t e;
    int st;
    bit bb;
    issue(0, 32'h99, 32'h5, 32'h0B0, 1'b0, 1'b0, 1'b0, 1'b1, st, bb);
    e = sbq0.pop_front();
    tests++;
    if (st !== 0 || p4wd[0] !== e.wdata || p4alu[0] !== e.alu || p4ins[0] !== e.ins || p4we[0] !== e.we) begin
      fails++; $display("FAIL passthrough: got stalls=%0d wd=%h ins=%h we=%b want 0/%h/%h/%b", st, p4wd[0], p4ins[0], p4we[0], e.wdata, e.ins, e.we);
    end
  endtask

  task automatic test_store_load;
    exp_t e;
    int st;
    bit bb;
    issue(0, 32'h4, 32'hDEAD, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, st, bb);
    e = sbq0.pop_front();
    tests++;
    if (st !== 1 || bb !== 1'b0) begin
      fails++; $display("FAIL store_stall: got stalls=%0d bubble_bad=%b want 1/0", st, bb);
    end
    tests++;
    if (p4wd[0] !== e.wdata || p4ins[0] !== e.ins || p4we[0] !== 1'b0) begin
      fails++; $display("FAIL store_capture: got wd=%h ins=%h want %h/%h", p4wd[0], p4ins[0], e.wdata, e.ins);
    end
    issue(0, 32'h4, 32'h0, 32'h101, 1'b1, 1'b0, 1'b1, 1'b1, st, bb);
    e = sbq0.pop_front();
    tests++;
    if (st !== 1 || bb !== 1'b0 || p4wd[0] !== 32'hDEAD || p4wd[0] !== e.wdata || p4md[0] !== e.mdata || p4we[0] !== 1'b1) begin
      fails++; $display("FAIL load_after_store: got stalls=%0d wd=%h md=%h want 1/dead/dead", st, p4wd[0], p4md[0]);
    end
  endtask

  task automatic test_wrap;
    exp_t e;
    int st;
    bit bb;
    issue(0, 32'd259, 32'h1234, 32'h110, 1'b0, 1'b1, 1'b0, 1'b0, st, bb);
    e = sbq0.pop_front();
    issue(0, 32'd3, 32'h0, 32'h111, 1'b1, 1'b0, 1'b1, 1'b1, st, bb);
    e = sbq0.pop_front();
    tests++;
    if (p4wd[0] !== 32'h1234 || p4wd[0] !== e.wdata) begin
      fails++; $display("FAIL wrap_load: got %h want 1234", p4wd[0]);
    end
  endtask

  task automatic test_read_write_same;
    exp_t e;
    int st;
    bit bb;
    issue(0, 32'd7, 32'h11, 32'h120, 1'b0, 1'b1, 1'b0, 1'b0, st, bb);
    e = sbq0.pop_front();
    issue(0, 32'd7, 32'h22, 32'h121, 1'b1, 1'b1, 1'b0, 1'b0, st, bb);
    e = sbq0.pop_front();
    tests++;
    if (st !== 1 || p4md[0] !== 32'h11 || p4md[0] !== e.mdata) begin
      fails++; $display("FAIL rw_old_data: got stalls=%0d md=%h want 1/11", st, p4md[0]);
    end
    issue(0, 32'd7, 32'h0, 32'h122, 1'b1, 1'b0, 1'b1, 1'b1, st, bb);
    e = sbq0.pop_front();
    tests++;
    if (p4wd[0] !== 32'h22 || p4wd[0] !== e.wdata) begin
      fails++; $display("FAIL rw_later_load: got %h want 22", p4wd[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] addr_t [6] = '{32'd30, 32'd30, 32'd31, 32'd32, 32'd31, 32'd32};
    logic [31:0] data_t [6] = '{32'hA0, 32'h0, 32'hB1, 32'hC2, 32'h0, 32'h0};
    bit          st_t   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_t e;
    int st;
    bit bb;
    for (int i = 0; i < 6; i++) begin
      issue(0, addr_t[i], data_t[i], 32'h200 + 32'(i), ~st_t[i], st_t[i], ~st_t[i], ~st_t[i], st, bb);
      e = sbq0.pop_front();
      tests++;
      if (st !== 1 || bb !== 1'b0 || p4wd[0] !== e.wdata || p4ins[0] !== e.ins || p4we[0] !== e.we) begin
        fails++; $display("FAIL back_to_back[%0d]: got stalls=%0d wd=%h ins=%h want 1/%h/%h", i, st, p4wd[0], p4ins[0], e.wdata, e.ins);
      end
    end
    idle(0);
  endtask

  task automatic test_lat1;
    exp_t e;
    int st;
    bit bb;
    for (int i = 0; i < 4; i++) begin
      issue(1, 32'd40 + 32'(i), 32'h5 + 32'h111 * 32'(i), 32'h300 + 32'(i), 1'b0, 1'b1, 1'b0, 1'b0, st, bb);
      e = sbq1.pop_front();
      tests++;
      if (st !== 0 || p4ins[1] !== e.ins || p4wd[1] !== e.wdata) begin
        fails++; $display("FAIL lat1_store[%0d]: got stalls=%0d ins=%h want 0/%h", i, st, p4ins[1], e.ins);
      end
      issue(1, 32'd40 + 32'(i), 32'h0, 32'h310 + 32'(i), 1'b1, 1'b0, 1'b1, 1'b1, st, bb);
      e = sbq1.pop_front();
      tests++;
      if (st !== 0 || p4wd[1] !== e.wdata || p4we[1] !== 1'b1) begin
        fails++; $display("FAIL lat1_load[%0d]: got stalls=%0d wd=%h want 0/%h", i, st, p4wd[1], e.wdata);
      end
    end
    idle(1);
  endtask

  task automatic test_reset_abort;
    exp_t e;
    int st;
    bit bb;
    issue(0, 32'd9, 32'h44, 32'h400, 1'b0, 1'b1, 1'b0, 1'b0, st, bb);
    e = sbq0.pop_front();
    // Aborted store: not pushed to the scoreboard and not applied to the model.
    drive(0, 32'd9, 32'h55, 32'h401, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({p4alu[0], p4md[0], p4wd[0], p4ins[0], p4we[0]} !== '0 || stall_o[0] !== 1'b0) begin
      fails++; $display("FAIL abort_outputs: got wd=%h ins=%h stall=%b want 0", p4wd[0], p4ins[0], stall_o[0]);
    end
    idle(0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    issue(0, 32'd9, 32'h0, 32'h402, 1'b1, 1'b0, 1'b1, 1'b1, st, bb);
    e = sbq0.pop_front();
    tests++;
    if (p4wd[0] !== 32'h44 || p4wd[0] !== e.wdata) begin
      fails++; $display("FAIL abort_no_write: got %h want 44", p4wd[0]);
    end
    idle(0);
  endtask

  initial begin
    idle(0);
    idle(1);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_passthrough();
    test_store_load();
    test_wrap();
    test_read_write_same();
    test_back_to_back();
    test_lat1();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage plus MEM/WB pipeline register. Consumes the EX/MEM register outputs, performs the load/store against a private word-addressed data memory with a configurable multi-cycle access latency, and stalls the front of the pipeline while an access is in flight. Registers the write-back bundle (ALU result, load data, selected write-back value, destination instruction, RF write enable) for the WB stage.

## Interface
Parameters:
- DATA_WORDS, 256, data-memory depth in words (power of two); ADDR_W = log2(DATA_WORDS)
- MEM_LATENCY, 2, cycles per load/store access (≥1; 1 = single-cycle, no stall)

Ports (widths use `WORD_LEN` and `INSTRUCTION_LEN` from defines.sv):
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- PR3_alu_out  in  WORD_LEN  ALU result; memory address for loads/stores
- PR3_RF_out2  in  WORD_LEN  store data
- PR3_instruction  in  INSTRUCTION_LEN  instruction in MEM
- PR3_MEM_read, PR3_MEM_write  in  1  load / store request
- PR3_sel_RF_write_src_ALU, PR3_sel_RF_write_src_MEM  in  1  write-back source select
- PR3_RF_write_en  in  1  RF write enable
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- PR4_alu_out, PR4_mem_data, PR4_write_data  out  WORD_LEN  registered ALU result, load data, selected write-back value
- PR4_instruction  out  INSTRUCTION_LEN  registered instruction
- PR4_RF_write_en  out  1  registered RF write enable

## Operation
- mem_op = PR3_MEM_read | PR3_MEM_write. Word address = PR3_alu_out[ADDR_W-1:0] (upper bits ignored; addresses wrap modulo DATA_WORDS).
- FSM states IDLE, ACCESS; 2-bit-or-wider counter cnt (0..MEM_LATENCY-1).
- IDLE: if mem_op and MEM_LATENCY>1 → ACCESS, cnt←1, mem_stall=1. If mem_op and MEM_LATENCY=1 → access completes this cycle, stay IDLE.
- ACCESS: mem_stall=1 while cnt<MEM_LATENCY-1, cnt←cnt+1. When cnt=MEM_LATENCY-1: completion cycle, mem_stall=0, → IDLE, cnt←0.
- mem_stall is combinational from state/cnt/mem_op; never high when mem_op=0.
- Completion cycle: store writes PR3_RF_out2 to memory once; load reads memory (read-before-write). No memory write on stalled cycles.
- Read and write both asserted: treated as store; PR4_mem_data gets the old word.
- Write-back select: sel_MEM → load data; else ALU result. Both selects high → MEM wins.
- PR4 capture: every non-stalled cycle PR4_* ← current bundle. Stalled cycle: bubble, PR4_RF_write_en←0, PR4_instruction←0, data outputs hold.
- Non-memory instructions pass through with one-cycle latency, no stall.

## Timing
- Reset: all PR4_* outputs 0, state IDLE, cnt 0; memory contents not reset (undefined until written). mem_stall=0 while rst high.
- Reset mid-access: FSM aborts to IDLE, no memory write occurs, outputs 0.
- Load/store latency: MEM_LATENCY cycles from first presentation to PR4 capture edge; mem_stall high for MEM_LATENCY-1 cycles.
- Back-to-back memory ops: second op enters IDLE the cycle after completion, stalling again; no lost or duplicated accesses.
- Store followed immediately by load of same address returns the stored value.

## Structure
- Package mem_stage_pkg: state enum {IDLE, ACCESS}, DATA_WORDS and MEM_LATENCY defaults; word/instruction widths stay in defines.sv.
- Sub-module data_memory: DATA_WORDS×WORD_LEN array, synchronous write on we, asynchronous read; no reset.
- Top holds FSM, counter, write-back mux, PR4 register.

## Test plan
- Reset: assert rst mid-run → all PR4_* 0, mem_stall 0; release, ALU op alu_out=0x15, RF_write_en=1 → PR4_write_data=0x15 next edge.
- Store/load, MEM_LATENCY=2: store 0xDEAD to addr 4 → mem_stall high exactly 1 cycle, PR4_RF_write_en=0 during bubble; load addr 4 with sel_MEM → PR4_write_data=0xDEAD after 2 cycles.
- Wrap: store 0x1234 with alu_out=DATA_WORDS+3 → load alu_out=3 returns 0x1234.
- MEM_LATENCY=1: alternating stores/loads → mem_stall never asserted, each result at next edge.
- Read+write same cycle, addr 7 previously 0x11, store 0x22 → PR4_mem_data=0x11, later load returns 0x22.
- Reset asserted during ACCESS of store 0x55 to addr 9 (previously 0x44) → subsequent load addr 9 returns 0x44.
